// File: rtl/sniffer_pkg.sv
// Shared types, ASCII constants and helpers for the digit run sniffer.
package sniffer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SEP, S_REJECT} scan_state_t;
    typedef enum logic [1:0] {E_IDLE, E_DIGIT, E_DELIM} emit_state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
    endfunction

endpackage

// File: rtl/run_emitter.sv
// Replays an accepted run from a shadow copy, one byte per clock, then a delimiter.
module run_emitter
    import sniffer_pkg::*;
#(
    parameter int unsigned DIGITS = 9,
    parameter logic [7:0]  DELIM  = 8'h20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [DIGITS*8-1:0] digits,
    output logic [7:0]          data_out,
    output logic                write
);

    localparam int unsigned    IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    emit_state_t         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIGITS*8-1:0] shadow_q, shadow_d;
    logic [7:0]          data_d;
    logic                write_d;

    // Next-state and output byte selection; a load always wins so a new run can
    // start while the previous delimiter goes out.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        data_d   = data_out;
        write_d  = 1'b0;
        unique case (state_q)
            E_DIGIT: begin
                data_d  = shadow_q[idx_q*8 +: 8];
                write_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = E_DELIM;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            E_DELIM: begin
                data_d  = DELIM;
                write_d = 1'b1;
                state_d = E_IDLE;
            end
            default: ;
        endcase
        if (load) begin
            shadow_d = digits;
            idx_d    = '0;
            state_d  = E_DIGIT;
        end
    end

    // State, shadow buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= E_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            data_out <= 8'h00;
            write    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            data_out <= data_d;
            write    <= write_d;
        end
    end

endmodule

// File: rtl/digit_run_sniffer.sv
// Scans an ASCII byte stream for runs of exactly DIGITS decimal digits (optionally
// grouped by a separator) and re-emits each accepted run followed by a delimiter.
module digit_run_sniffer
    import sniffer_pkg::*;
#(
    parameter int unsigned DIGITS   = 9,
    parameter int unsigned GROUP    = 3,
    parameter int unsigned SEP_MODE = 1,
    parameter logic [7:0]  SEP      = 8'h20,
    parameter logic [7:0]  DELIM    = 8'h20,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             write,
    output logic [CNT_W-1:0] match_count
);

    localparam int unsigned      RUN_W    = $clog2(DIGITS + 1);
    localparam logic [RUN_W-1:0] DIGITS_C = RUN_W'(DIGITS);

    scan_state_t         scan_q, scan_d;
    logic [RUN_W-1:0]    cnt_q, cnt_d;
    logic [DIGITS*8-1:0] digits_q, digits_d;
    logic                load;
    logic                digit;
    logic                sep_ok;

    assign digit  = is_digit(data_in);
    // A separator is only legal at a group boundary strictly inside the run.
    assign sep_ok = (SEP_MODE == 1) && (data_in == SEP) && (cnt_q < DIGITS_C) &&
                    ((32'(cnt_q) % GROUP) == 0);

    // Scanner next-state: collects digits, detects accept on the terminator.
    always_comb begin
        scan_d   = scan_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        load     = 1'b0;
        if (enable) begin
            unique case (scan_q)
                S_IDLE: begin
                    if (digit) begin
                        scan_d        = S_RUN;
                        cnt_d         = RUN_W'(1);
                        digits_d[7:0] = data_in;
                    end
                end
                S_RUN: begin
                    if (digit) begin
                        if (cnt_q < DIGITS_C) begin
                            digits_d[cnt_q*8 +: 8] = data_in;
                            cnt_d                  = cnt_q + 1'b1;
                        end else begin
                            scan_d = S_REJECT;
                        end
                    end else if (sep_ok) begin
                        scan_d = S_SEP;
                    end else begin
                        load   = (cnt_q == DIGITS_C);
                        scan_d = S_IDLE;
                    end
                end
                S_SEP: begin
                    if (digit) begin
                        digits_d[cnt_q*8 +: 8] = data_in;
                        cnt_d                  = cnt_q + 1'b1;
                        scan_d                 = S_RUN;
                    end else begin
                        scan_d = S_IDLE;
                    end
                end
                S_REJECT: begin
                    if (!digit) begin
                        scan_d = S_IDLE;
                    end
                end
                default: scan_d = S_IDLE;
            endcase
        end
    end

    // Scanner state, digit counter and collection buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q   <= S_IDLE;
            cnt_q    <= '0;
            digits_q <= '0;
        end else begin
            scan_q   <= scan_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
        end
    end

    // Saturating count of accepted runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_count <= '0;
        end else if (load && (match_count != '1)) begin
            match_count <= match_count + 1'b1;
        end
    end

    run_emitter #(
        .DIGITS (DIGITS),
        .DELIM  (DELIM)
    ) u_emitter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .digits   (digits_q),
        .data_out (data_out),
        .write    (write)
    );

endmodule

// File: tb/tb_digit_run_sniffer.sv
// Directed bench for digit_run_sniffer: expected output bytes with their exact
// output cycle are queued when the terminator is driven and checked every cycle.
module tb_digit_run_sniffer;
    import sniffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en_a, en_b;
    logic [7:0]  din_a, din_b;
    logic [7:0]  dout_a, dout_b;
    logic        wr_a, wr_b;
    logic [15:0] mc_a, mc_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_k;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digit_run_sniffer dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en_a),
        .data_in     (din_a),
        .data_out    (dout_a),
        .write       (wr_a),
        .match_count (mc_a)
    );

    digit_run_sniffer #(
        .DIGITS   (4),
        .GROUP    (2),
        .SEP_MODE (0)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (en_b),
        .data_in     (din_b),
        .data_out    (dout_b),
        .write       (wr_b),
        .match_count (mc_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Queue each byte of a run for output at edges k+1, k+2, ...
    task automatic expect_run(input int sel, input int k, input string emit);
        exp_t e;
        for (int j = 0; j < emit.len(); j++) begin
            e.cyc = k + 1 + j;
            e.val = emit[j];
            if (sel == 0) q_a.push_back(e);
            else          q_b.push_back(e);
        end
    endtask

    // Drive a string one byte per clock; acc1/acc2 mark accepting terminators.
    task automatic feed(input int sel, input string s, input int acc1, input int acc2,
                        input string emit);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            if (sel == 0) begin din_a = s[i]; en_a = 1'b1; end
            else          begin din_b = s[i]; en_b = 1'b1; end
            if (i == acc1 || i == acc2) begin
                last_k = cyc + 1;
                expect_run(sel, cyc + 1, emit);
            end
        end
        @(negedge clk);
        if (sel == 0) en_a = 1'b0;
        else          en_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitors: every cycle either an expected byte or write=0.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q_a.size() > 0 && q_a[0].cyc == cyc) begin
                chk("a_write", 32'(wr_a), 32'd1);
                chk("a_byte", 32'(dout_a), 32'(q_a[0].val));
                void'(q_a.pop_front());
            end else begin
                chk("a_quiet", 32'(wr_a), 32'd0);
            end
            if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
                chk("b_write", 32'(wr_b), 32'd1);
                chk("b_byte", 32'(dout_b), 32'(q_b[0].val));
                void'(q_b.pop_front());
            end else begin
                chk("b_quiet", 32'(wr_b), 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b0;
        din_a = 8'h00;
        din_b = 8'h00;
        idle(2);
        chk("reset_dout_a", 32'(dout_a), 32'h0);
        chk("reset_write_a", 32'(wr_a), 32'h0);
        chk("reset_count_a", 32'(mc_a), 32'h0);
        chk("reset_write_b", 32'(wr_b), 32'h0);
        chk("reset_count_b", 32'(mc_b), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Grouped run and a plain run in one stream
        feed(0, "a729 892 561ff729892561gsdf", 12, 23, "729892561 ");
        idle(12);
        chk("a_count_two", 32'(mc_a), 32'd2);

        // Ten digits: too long, then a clean nine-digit run
        feed(0, "1234567890", -1, -1, "");
        chk("a_reject_state", 32'(dut_a.scan_q), 32'(S_REJECT));
        feed(0, "x", -1, -1, "");
        chk("a_count_after_reject", 32'(mc_a), 32'd2);
        feed(0, "123456789x", 9, -1, "123456789 ");
        idle(11);
        chk("a_count_three", 32'(mc_a), 32'd3);

        // Separator misuse drops the run; trailing separator terminates
        feed(0, "12 3456789x", -1, -1, "");
        feed(0, "123  456789x", -1, -1, "");
        feed(0, "123 456 789 q", 11, -1, "123456789 ");
        idle(11);
        chk("a_count_four", 32'(mc_a), 32'd4);

        // Back-to-back accepts: second run starts right after the first delimiter
        feed(0, "123456789x123456789y", 9, 19, "123456789 ");
        idle(11);
        chk("a_count_six", 32'(mc_a), 32'd6);

        // No separators, four digits
        feed(1, "12 34 5678;", 10, -1, "5678 ");
        idle(6);
        chk("b_count_one", 32'(mc_b), 32'd1);

        // Scanner frozen mid-run; bytes presented while frozen are ignored
        feed(0, "1234", -1, -1, "");
        repeat (3) begin
            @(negedge clk);
            din_a = "9";
            en_a  = 1'b0;
        end
        feed(0, "56789.", 5, -1, "123456789 ");
        idle(11);
        chk("a_count_freeze", 32'(mc_a), 32'd7);

        // Enable low with digit garbage while the emitter drains
        feed(0, "987654321z", 9, -1, "987654321 ");
        repeat (11) begin
            @(negedge clk);
            din_a = 8'h35;
            en_a  = 1'b0;
        end
        chk("a_count_drain", 32'(mc_a), 32'd8);

        // Asynchronous reset at the fourth emitted digit
        feed(0, "111222333!", 9, -1, "111222333 ");
        wait (cyc == last_k + 4);
        #2;
        chk("a_write_before_reset", 32'(wr_a), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("a_write_async_reset", 32'(wr_a), 32'd0);
        chk("a_dout_async_reset", 32'(dout_a), 32'd0);
        chk("a_count_async_reset", 32'(mc_a), 32'd0);
        chk("b_count_async_reset", 32'(mc_b), 32'd0);
        q_a.delete();
        idle(2);
        rst_n = 1'b1;
        feed(0, "555666777.", 9, -1, "555666777 ");
        idle(11);
        chk("a_count_after_reset", 32'(mc_a), 32'd1);

        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
